// File: rtl/full_adder.sv
// Ripple-carry adder of a + b + cin built from per-bit full-adder cells, with a
// zero-latency combinational result and a one-cycle registered copy.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             en,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             vld_q
);

  // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .c  (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];
  // For WIDTH=1 carry[0] is cin, so this reduces to cin ^ cout
  assign ovf  = carry[WIDTH-1] ^ carry[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else if (en) begin
      sum_q  <= sum;
      cout_q <= cout;
      ovf_q  <= ovf;
      vld_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: a WIDTH=1 and a WIDTH=8 instance sharing
// clock, reset and enable.

module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;

  logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       sum1, cout1, ovf1, sum1_q, cout1_q, ovf1_q, vld1_q;

  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic [7:0] sum8, sum8_q;
  logic       cout8, ovf8, cout8_q, ovf8_q, vld8_q;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .en(en),
    .sum(sum1), .cout(cout1), .ovf(ovf1),
    .sum_q(sum1_q), .cout_q(cout1_q), .ovf_q(ovf1_q), .vld_q(vld1_q)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .en(en),
    .sum(sum8), .cout(cout8), .ovf(ovf8),
    .sum_q(sum8_q), .cout_q(cout8_q), .ovf_q(ovf8_q), .vld_q(vld8_q)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pops one expected entry, compares it with the observed value
  task automatic pop_chk(input string tag, input logic [63:0] got);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty got=%0h exp=entry", tag, got);
    end else begin
      e = exp_q.pop_front();
      chk(tag, got, e);
    end
  endtask

  function automatic logic [10:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
    // {ovf, cout, sum}; overflow from the signed-range test
    int          s;
    logic [8:0]  u;
    logic        o;
    u = {1'b0, a} + {1'b0, b} + {8'd0, c};
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    o = (s > 127) || (s < -128);
    return {1'b0, o, u};
  endfunction

  initial begin
    logic [1:0]  tab [8];
    logic [2:0]  v;
    logic [10:0] r;
    logic [10:0] m8;     // {vld, ovf, cout, sum} model of the WIDTH=8 registers
    logic        en_r;
    tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // WIDTH=1 exhaustive combinational sweep
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, cin1} = v;
      exp_q.push_back(64'({tab[i][1] ^ v[0], tab[i]}));
      #10;
      pop_chk($sformatf("w1_comb_%0d", i), 64'({ovf1, cout1, sum1}));
    end

    // Reset wins over en; comb path keeps tracking
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1;
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w1_q", 64'({vld1_q, ovf1_q, cout1_q, sum1_q}), 64'd0);
    chk("rst_w8_q", 64'({vld8_q, ovf8_q, cout8_q, sum8_q}), 64'd0);
    chk("rst_w1_comb", 64'({cout1, sum1}), 64'b10);
    chk("rst_w8_comb", 64'({cout8, sum8}), 64'h046);

    // Capture then hold, WIDTH=1
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    @(posedge clk); #1;
    chk("cap_w1_q", 64'({vld1_q, ovf1_q, cout1_q, sum1_q}), 64'b1110);
    @(negedge clk);
    en = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1;
    @(posedge clk); #1;
    chk("hold_w1_q", 64'({vld1_q, ovf1_q, cout1_q, sum1_q}), 64'b1110);
    chk("hold_w1_comb", 64'({cout1, sum1}), 64'b01);

    // WIDTH=8 directed boundaries
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; #1;
    chk("w8_wrap", 64'({ovf8, cout8, sum8}), 64'({1'b0, 1'b1, 8'h00}));
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; #1;
    chk("w8_ovf", 64'({ovf8, cout8, sum8}), 64'({1'b1, 1'b0, 8'h80}));
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; #1;
    chk("w8_allones", 64'({ovf8, cout8, sum8}), 64'({1'b0, 1'b1, 8'hFF}));
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; #1;
    chk("w8_negovf", 64'({ovf8, cout8, sum8}), 64'({1'b1, 1'b1, 8'h00}));

    // WIDTH=8 random with registered-path scoreboard; the WIDTH=1 regs were
    // captured earlier and are not tracked here
    m8 = {1'b1, 2'b00, 8'h46};  // last WIDTH=8 capture during the hold test
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    chk("w8_q_seed", 64'({vld8_q, ovf8_q, cout8_q, sum8_q}), 64'({1'b1, 2'b00, 8'h46}));
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      en_r = ($urandom_range(0, 3) != 0);
      en   = en_r;
      rst_n = !(i == 500 || i == 501);
      #1;
      r = ref8(a8, b8, cin8);
      chk($sformatf("w8_rand_comb_%0d", i), 64'({ovf8, cout8, sum8}), 64'(r[9:0]));
      if (!rst_n)     m8 = '0;
      else if (en_r)  m8 = {1'b1, r[9:0]};
      exp_q.push_back(64'(m8));
      @(posedge clk); #1;
      pop_chk($sformatf("w8_rand_q_%0d", i), 64'({vld8_q, ovf8_q, cout8_q, sum8_q}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
